// File: rtl/mips_defs.sv
// Shared MIPS encoding constants and field helpers for fetch, queue and decode.
package mips_defs;
  localparam logic [5:0]  OP_J     = 6'h02;
  localparam logic [5:0]  OP_JAL   = 6'h03;
  localparam logic [31:0] RESET_PC = 32'h0040_0000;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;
  localparam int TGT_HI = 25;
  localparam int TGT_LO = 0;

  // Only the plain J form is flagged; JAL also writes a link register and is left to decode.
  function automatic logic is_j_op(input logic [31:0] inst);
    return inst[OPC_HI:OPC_LO] == OP_J;
  endfunction
endpackage

// File: rtl/fq_predecode.sv
// Combinational jump pre-decode: flags J opcodes, forms pc+4 and the pseudo-direct target.
// Zero latency, no state; shared between the fetch queue head and decode.
module fq_predecode
  import mips_defs::*;
(
  input  logic [31:0] inst_i,
  input  logic [31:0] pc_i,
  output logic        is_jump_o,
  output logic [31:0] pc_plus4_o,
  output logic [31:0] jump_addr_o
);

  assign is_jump_o   = is_j_op(inst_i);
  assign pc_plus4_o  = pc_i + 32'd4;
  assign jump_addr_o = {pc_plus4_o[31:28], inst_i[TGT_HI:TGT_LO], 2'b00};

endmodule

// File: rtl/fetch_queue.sv
// Show-ahead prefetch FIFO between fetch and decode; push-to-output latency is one cycle.
// Accepts only when not full (independent of out_ready); flush discards everything.
module fetch_queue
  import mips_defs::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_inst,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_inst,
  output logic [31:0]      out_pc_plus4,
  output logic             out_is_jump,
  output logic [31:0]      out_jump_addr,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  logic [31:0]      pc_q   [DEPTH];
  logic [31:0]      inst_q [DEPTH];
  logic [DEPTH-1:0] jump_q;

  logic push, pop, head_vld;
  logic [31:0] hd_pc, hd_inst, hd_pc_plus4, hd_jump_addr;
  logic hd_is_jump;

  // Full is a registered-count decision, so a pop in the same cycle never frees a slot early.
  assign in_ready = (count_q != CNT_FULL);
  assign head_vld = (count_q != '0);
  assign push     = in_valid && in_ready && !flush;
  assign pop      = head_vld && out_ready && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry payload needs no reset: validity is carried entirely by count_q.
  always_ff @(posedge clock) begin
    if (push) begin
      pc_q[wr_ptr_q]   <= in_pc;
      inst_q[wr_ptr_q] <= in_inst;
      jump_q[wr_ptr_q] <= is_j_op(in_inst);
    end
  end

  assign hd_pc   = pc_q[rd_ptr_q];
  assign hd_inst = inst_q[rd_ptr_q];

  fq_predecode u_head_predecode (
    .inst_i      (hd_inst),
    .pc_i        (hd_pc),
    .is_jump_o   (hd_is_jump),
    .pc_plus4_o  (hd_pc_plus4),
    .jump_addr_o (hd_jump_addr)
  );

  // The flag captured at enqueue must match a fresh decode of the stored word.
  always_comb begin
    if (head_vld) assert (hd_is_jump == jump_q[rd_ptr_q]);
  end

  assign out_valid     = head_vld;
  assign out_pc        = head_vld ? hd_pc        : 32'h0;
  assign out_inst      = head_vld ? hd_inst      : 32'h0;
  assign out_pc_plus4  = head_vld ? hd_pc_plus4  : 32'h0;
  assign out_jump_addr = head_vld ? hd_jump_addr : 32'h0;
  assign out_is_jump   = head_vld && jump_q[rd_ptr_q];
  assign count         = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboarded random + directed bench for fetch_queue against a queue-based reference.
module tb_fetch_queue;
  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready, flush, out_valid, out_ready, out_is_jump;
  logic [31:0] in_pc, in_inst, out_pc, out_inst, out_pc_plus4, out_jump_addr;
  logic [2:0]  count;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t exp_q[$];
  int tests = 0;
  int fails = 0;

  fetch_queue #(.DEPTH(4), .PTR_W(2)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .out_pc_plus4(out_pc_plus4), .out_is_jump(out_is_jump), .out_jump_addr(out_jump_addr),
    .count(count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  function automatic logic [31:0] ref_target(input logic [31:0] pc, input logic [31:0] inst);
    return ((pc + 32'd4) & 32'hF000_0000) | ((inst & 32'h03FF_FFFF) << 2);
  endfunction

  function automatic logic ref_is_jump(input logic [31:0] inst);
    return (inst >> 26) == 32'd2;
  endfunction

  // Monitor: compares the visible head and status, then applies this cycle's handshakes to the model.
  always @(negedge clock) begin
    int  sz;
    bit  acc, take;
    ent_t e;
    if (!reset_n) begin
      exp_q.delete();
    end else begin
      sz = exp_q.size();
      chk("count", 32'(count), 32'(sz));
      chk("in_ready", 32'(in_ready), 32'(sz != DEPTH));
      chk("out_valid", 32'(out_valid), 32'(sz != 0));
      if (sz != 0) begin
        e = exp_q[0];
        chk("out_pc", out_pc, e.pc);
        chk("out_inst", out_inst, e.inst);
        chk("out_pc_plus4", out_pc_plus4, ref_plus4(e.pc));
        chk("out_jump_addr", out_jump_addr, ref_target(e.pc, e.inst));
        chk("out_is_jump", 32'(out_is_jump), 32'(ref_is_jump(e.inst)));
      end else begin
        chk("idle_out_pc", out_pc, 32'h0);
        chk("idle_out_pc_plus4", out_pc_plus4, 32'h0);
        chk("idle_out_jump", 32'(out_is_jump), 32'h0);
      end
      if (flush) begin
        exp_q.delete();
      end else begin
        acc  = in_valid && (sz != DEPTH);
        take = out_ready && (sz != 0);
        if (take) void'(exp_q.pop_front());
        if (acc) exp_q.push_back('{pc: in_pc, inst: in_inst});
      end
    end
  end

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                       input logic rdy, input logic fl);
    @(posedge clock);
    #1;
    in_valid  = v;
    in_pc     = pc;
    in_inst   = inst;
    out_ready = rdy;
    flush     = fl;
  endtask

  task automatic idle(input logic rdy);
    drive(1'b0, 32'h0, 32'h0, rdy, 1'b0);
  endtask

  initial begin
    logic [31:0] rpc, rinst;
    reset_n = 1'b0; in_valid = 1'b0; in_pc = '0; in_inst = '0; out_ready = 1'b0; flush = 1'b0;
    #2;
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    #10 reset_n = 1'b1;

    // Fill to full, refuse a fifth word, drain in order.
    for (int i = 0; i < 4; i++) drive(1'b1, 32'h0040_0000 + 32'(4*i), 32'h2000_0000 + 32'(i), 1'b0, 1'b0);
    idle(1'b0);
    chk("full_count", 32'(count), 32'd4);
    chk("full_in_ready", 32'(in_ready), 32'h0);
    drive(1'b1, 32'h0040_0010, 32'h2000_0004, 1'b1, 1'b0);
    chk("full_head", out_pc, 32'h0040_0000);
    idle(1'b1);
    chk("no_5th_count", 32'(count), 32'd3);
    repeat (4) idle(1'b1);
    chk("drained", 32'(count), 32'h0);

    // Steady push/pop at two entries across pointer wrap.
    drive(1'b1, 32'h0000_1000, 32'h1, 1'b0, 1'b0);
    drive(1'b1, 32'h0000_1004, 32'h2, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) drive(1'b1, 32'h0000_1008 + 32'(4*i), 32'(i + 3), 1'b1, 1'b0);
    idle(1'b0);
    chk("pushpop_count", 32'(count), 32'd2);
    chk("pushpop_head", out_pc, 32'h0000_1020);
    repeat (2) idle(1'b1);

    // Jump predecode, then an all-zero word forwarded as ordinary data.
    drive(1'b1, 32'h0040_0008, 32'h0810_0010, 1'b0, 1'b0);
    idle(1'b0);
    chk("j_is_jump", 32'(out_is_jump), 32'h1);
    chk("j_plus4", out_pc_plus4, 32'h0040_000C);
    chk("j_target", out_jump_addr, 32'h0040_0040);
    drive(1'b1, 32'h0040_0010, 32'h0, 1'b1, 1'b0);
    idle(1'b0);
    chk("zero_valid", 32'(out_valid), 32'h1);
    chk("zero_is_jump", 32'(out_is_jump), 32'h0);
    chk("zero_pc", out_pc, 32'h0040_0010);
    idle(1'b1);

    // Flush with a concurrent push and pop at three entries.
    for (int i = 0; i < 3; i++) drive(1'b1, 32'h0000_2000 + 32'(4*i), 32'h3, 1'b0, 1'b0);
    drive(1'b1, 32'hDEAD_BEE0, 32'h4, 1'b1, 1'b1);
    idle(1'b0);
    chk("flush_count", 32'(count), 32'h0);
    chk("flush_valid", 32'(out_valid), 32'h0);
    drive(1'b1, 32'h0000_3000, 32'h5, 1'b0, 1'b0);
    idle(1'b1);
    chk("post_flush_head", out_pc, 32'h0000_3000);
    idle(1'b0);

    // Empty-queue latency and pc+4 wrap.
    drive(1'b1, 32'hFFFF_FFFC, 32'h0BFF_FFFF, 1'b0, 1'b0);
    chk("lat_cycle_n", 32'(out_valid), 32'h0);
    idle(1'b0);
    chk("lat_cycle_n1", 32'(out_valid), 32'h1);
    chk("wrap_plus4", out_pc_plus4, 32'h0);
    chk("wrap_target", out_jump_addr, 32'h0FFF_FFFC);
    idle(1'b1);

    // Asynchronous reset between edges with three entries held.
    for (int i = 0; i < 3; i++) drive(1'b1, 32'h0000_4000 + 32'(4*i), 32'h6, 1'b0, 1'b0);
    idle(1'b0);
    chk("pre_rst_count", 32'(count), 32'd3);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_count", 32'(count), 32'h0);
    chk("async_rst_valid", 32'(out_valid), 32'h0);
    chk("async_rst_ready", 32'(in_ready), 32'h1);
    @(posedge clock);
    #3 reset_n = 1'b1;

    // Randomized traffic; scoreboard covers ordering, flushes and wrap.
    for (int i = 0; i < 3000; i++) begin
      rpc   = $urandom();
      rinst = $urandom();
      case ($urandom_range(0, 7))
        0: rinst = {6'h02, rinst[25:0]};
        1: rinst = 32'h0;
        2: rpc   = 32'hFFFF_FFFC;
        default: ;
      endcase
      drive(1'($urandom_range(0, 9) < 6), {rpc[31:2], 2'b00}, rinst,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) == 0));
    end
    idle(1'b1);
    repeat (6) idle(1'b1);
    chk("final_empty", 32'(count), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
